// File: rtl/inst_mem_loader.sv
// Instruction-memory program loader: takes a framed byte stream (N, 4*N LE payload bytes, checksum),
// writes words 0..N-1 into instruction memory and releases the core only after a verified load.
module inst_mem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [8:0] LP_MAX = 9'(MAX_WORDS);

  state_t            r_state;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   r_word_cnt;
  logic [1:0]        r_byte_cnt;
  logic [7:0]        r_sum;
  logic [23:0]       r_word;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_accept;
  logic [ADDR_W:0]   w_word_next;

  assign s_ready     = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_accept    = s_valid && s_ready;
  assign w_word_next = r_word_cnt + 1'b1;

  // Status flags are pure decodes of the state register, so they are sticky until the next start.
  assign busy      = s_ready || (r_state == S_WRITE);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_ERR);
  assign cpu_hold  = (r_state != S_DONE);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_word_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_sum       <= '0;
      r_word      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_HDR;
            r_sum      <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            r_n   <= (ADDR_W+1)'(s_data);
            r_sum <= s_data;
            if ({1'b0, s_data} > LP_MAX) r_state <= S_ERR;
            else if (s_data == 8'd0)     r_state <= S_CHK;
            else                         r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_sum      <= r_sum + s_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_word[7:0]   <= s_data;
              2'd1: r_word[15:8]  <= s_data;
              2'd2: r_word[23:16] <= s_data;
              default: begin
                // Fourth byte completes the word; the write strobe is live during WRITE.
                r_mem_wdata <= {s_data, r_word};
                r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
                r_mem_we    <= 1'b1;
                r_state     <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          r_word_cnt <= w_word_next;
          r_byte_cnt <= '0;
          r_state    <= (w_word_next == r_n) ? S_CHK : S_DATA;
        end
        S_CHK: begin
          if (w_accept) r_state <= (s_data == r_sum) ? S_DONE : S_ERR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Program loader and write-side master for the writable instruction memory. It accepts a framed byte stream from a host link with a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory at word indices 0..N-1. It verifies an 8-bit checksum and holds the core in reset until a load completes successfully.

Parameters:
ADDR_W, 8, width of the word-index write address into instruction memory
MAX_WORDS, 128, largest legal word count N in the header

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR
s_valid  in  1  host byte valid
s_data  in  8  host byte
s_ready  out  1  loader can accept a byte
mem_we  out  1  instruction memory write enable, one-cycle pulse
mem_addr  out  ADDR_W  word index to write
mem_wdata  out  32  instruction word to write
busy  out  1  high in HDR, DATA, WRITE and CHK
done  out  1  sticky flag: last load succeeded
err  out  1  sticky flag: last load failed
cpu_hold  out  1  holds the core in reset; low only in DONE

Behaviour:
- Byte transfer: a byte is accepted on a rising edge where s_valid=1 and s_ready=1. s_ready depends only on state, never on s_valid.
- s_ready is 1 in HDR, DATA and CHK, and 0 elsewhere.
- Frame format, in order:
  - Header: 1 byte, N.
  - Payload: 4*N bytes, little-endian per word. The first byte is bits [7:0].
  - Trailer: 1 checksum byte, equal to the mod-256 sum of the header byte and all payload bytes.
- State machine:
  - IDLE: start → HDR. Clear the sum, byte counter and word counter.
  - HDR: on accept, latch N and sum=N.
    - N > MAX_WORDS → ERR.
    - N == 0 → CHK.
    - Otherwise → DATA.
  - DATA: on each accept, shift the byte into the word register at lane byte_cnt and add it to the sum. byte_cnt counts 0..3. When the 4th byte is accepted → WRITE.
  - WRITE: one cycle.
    - mem_we=1, mem_addr=word_cnt, mem_wdata=assembled word.
    - Then word_cnt+1. If the new word_cnt == N → CHK, else → DATA with byte_cnt=0.
  - CHK: on accept, byte == sum → DONE, otherwise → ERR.
  - DONE: done=1, err=0, cpu_hold=0. start → HDR (clears done; cpu_hold rises again).
  - ERR: err=1, done=0, cpu_hold=1. start → HDR (clears err).
- Sticky flags: done and err each clear on the transition to HDR.
- start in HDR, DATA, WRITE or CHK is ignored.
- Throughput: at most one word per 5 cycles (4 accepts plus WRITE). Gaps on s_valid stall the machine without losing state.
- mem_addr and mem_wdata hold their last values when mem_we=0. Memory writes are not undone on a checksum failure.
- Reset values (any state, including mid-frame):
  - state=IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, err=0, cpu_hold=1.
  - All counters and the sum are 0; a partial word is discarded.
- Width rules:
  - Sum: 8-bit wrap.
  - word_cnt: ADDR_W+1 bits, so N=MAX_WORDS can be compared without overflow.
  - byte_cnt: 2 bits.

Test Plan:
- Good load, 2 words: start, then bytes 02, 93 00 10 00, 13 01 50 00, 09 → writes (addr 0, 0x00100093) and (addr 1, 0x00500113), each with a one-cycle mem_we. Then done=1, err=0, cpu_hold=0, busy=0.
- Bad checksum: same frame with trailer 0x0A → both writes occur, then err=1, done=0, cpu_hold=1.
- Oversize header 0x81 (129) → ERR right after the header accept, no mem_we, s_ready=0 afterwards. A second start followed by a good frame → done=1.
- Empty frame: start, bytes 00, 00 → no writes, done=1. Trailer 01 instead → err=1.
- Backpressure/gaps: 1-word frame 01, 13 00 00 00, 14 with s_valid low 3 cycles between bytes → single write (addr 0, 0x00000013), done=1. s_ready=0 during WRITE; a byte held on s_valid is accepted the next cycle. A start pulse mid-frame has no effect.
- Reset mid-load: assert rst after 2 payload bytes → next cycle IDLE, all outputs at reset values, no mem_we. A fresh start plus full frame loads correctly from addr 0.
